err_round_sched: RTL and testbench
==================================

// Module: err_round_sched
// PURPOSE
//  Shares one registered round-half-up unit among NUM_REQ error-product requesters, e.g. MAC lanes of the error-compensation array.
//  Round-robin arbitration, valid/ready on both sides, 2-stage pipeline, and run-time selection of kept MSB count m with a safe drain on reconfiguration.
//  Each result returns tagged with the requester id.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  DATA_W   16  error-product width
//  MSB_DEF  8   kept-MSB count m after reset (1..DATA_W)
// PORTS
//  clk        in   1                single clock, rising edge
//  rst_n      in   1                asynchronous active-low reset
//  req_valid  in   NUM_REQ          per-requester valid
//  req_data   in   NUM_REQ*DATA_W   error products, lane i at [i*DATA_W +: DATA_W]
//  req_ready  out  NUM_REQ          per-requester ready (one-hot or zero)
//  cfg_msb    in   5                new m value
//  cfg_load   in   1                1-cycle pulse, request m <= cfg_msb
//  resp_valid out  1                rounded result valid
//  resp_data  out  DATA_W           rounded product
//  resp_id    out  $clog2(NUM_REQ)  originating requester
//  resp_ready in   1                downstream accept
//  busy       out  1                any stage occupied or drain pending
// BEHAVIOUR
//  Reset: all outputs 0. m=MSB_DEF, RR pointer=NUM_REQ-1, FSM=IDLE, both stages empty.
//  Rounding: sh=DATA_W-m.
//    m<DATA_W: out=(x + (1<<(sh-1))) & ~((1<<sh)-1), evaluated mod 2^DATA_W (carry dropped, wraps).
//    m==DATA_W: out=x.
//  Arbitration: grant the first valid lane searching from ptr+1 upward, wrapping.
//    req_ready[g]=1 only for the granted lane, only in IDLE/RUN, only when S0 can load.
//    Accept = req_valid & req_ready. On accept, ptr<=g.
//    A lane may drop valid before accept without penalty.
//  Pipeline: S0 captures {data,id}; S1 holds the rounded result.
//    Accept at edge N -> resp_valid at edge N+2 (latency 2). Throughput 1/clk.
//    S1 loads when empty or resp_ready=1. S0 loads when empty or moving into S1.
//    resp_valid=1 && resp_ready=0: resp_data/resp_id hold stable; at most 2 items in flight.
//  FSM:
//    IDLE: pipeline empty -> RUN on accept.
//    RUN: -> IDLE when both stages empty and no accept.
//    DRAIN: entered on cfg_load while any stage is occupied. req_ready=0; new m applies on the cycle both stages are empty -> IDLE.
//    cfg_load in IDLE: m updates at the next edge, no drain.
//  Config rules:
//    cfg_msb of 0 or >DATA_W: ignored, m unchanged. FSM still follows the IDLE/DRAIN rules.
//    cfg_load during DRAIN: latest value wins; DRAIN is not restarted.
//    cfg_load and an accept in the same IDLE cycle: cfg_load wins, the accept is blocked (req_ready=0 that cycle).
//    In-flight items always use the m that was current at their accept.
//  Reset mid-operation drops in-flight items silently and returns all state to reset values.
// CONFIGURATION
//  ROUND_SAT_EN defined: if carry-out of the rounding add, out=((1<<DATA_W)-1) & ~((1<<sh)-1), e.g. 0xFF00 for m=8.
//  ROUND_SAT_EN undefined: carry dropped, result wraps, e.g. 0x0000.
//  m==DATA_W is unaffected either way.
// TESTING
//  1. m=8, lane0 sends 0x1234, 0x1280, 0x12FF -> resp 0x1200, 0x1300, 0x1300, id 0, each 2 cycles after accept.
//  2. m=8, 0xFF80 -> 0x0000 without ROUND_SAT_EN, 0xFF00 with it. m=16, 0xABCD -> 0xABCD.
//  3. All 4 lanes valid continuously, resp_ready=1 -> ids 0,1,2,3,0,1..., one per clk, no starvation.
//  4. resp_ready=0 for 5 cycles with 4 lanes valid -> exactly 2 accepts, resp_data stable; on release, in-order drain with no loss or duplication.
//  5. 2 items in flight, cfg_load with cfg_msb=4 -> req_ready=0 until empty; the in-flight items round with m=8; then 0x1880 -> 0x2000. cfg_msb=0 leaves m unchanged.
//  6. Assert rst_n low mid-stream -> resp_valid, req_ready and busy go 0 immediately, m returns to 8, no stale response after release.

Source files
------------

// File: rtl/err_round_sched.sv
// Shared registered round-half-up unit with round-robin arbitration across NUM_REQ requesters.
// Optional ROUND_SAT_EN: saturate to the largest kept-MSB value on rounding carry-out instead of wrapping.
`timescale 1ns/1ps
module err_round_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,   // up to 31, m is held in 5 bits
  parameter int MSB_DEF = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [4:0]                 cfg_msb,
  input  logic                       cfg_load,
  output logic                       resp_valid,
  output logic [DATA_W-1:0]          resp_data,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  input  logic                       resp_ready,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [4:0] MSB_RST = 5'(MSB_DEF);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid may drop before the transfer, and held response data never changes while
  // resp_valid=1 and resp_ready=0.
  state_t             state;
  logic [4:0]         m;
  logic [4:0]         m_pend;
  logic               live;     // keeps req_ready low through and just after reset
  logic [IDW-1:0]     ptr;

  logic               s0_valid;
  logic [DATA_W-1:0]  s0_data;
  logic [IDW-1:0]     s0_id;
  logic [4:0]         s0_m;
  logic               s1_valid;
  logic [DATA_W-1:0]  s1_data;
  logic [IDW-1:0]     s1_id;

  logic               grant_found;
  logic [IDW-1:0]     grant_id;
  logic               s1_load;
  logic               s0_can_load;
  logic               accept_en;
  logic               accept;
  logic               pipe_empty;
  logic               cfg_ok;

  function automatic logic [DATA_W-1:0] round_fn(input logic [DATA_W-1:0] x,
                                                 input logic [4:0] mm);
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] half;
    logic [DATA_W-1:0] res;
    int                sh;
    sh   = DATA_W - int'(mm);
    res  = x;
    sum  = '0;
    mask = '1;
    half = '0;
    if (sh > 0) begin
      mask = {DATA_W{1'b1}} << sh;
      half = DATA_W'(1) << (sh - 1);
      sum  = {1'b0, x} + {1'b0, half};
      res  = sum[DATA_W-1:0] & mask;
`ifdef ROUND_SAT_EN
      if (sum[DATA_W]) res = mask;
`else
      res = sum[DATA_W-1:0] & mask;
`endif
    end
    return res;
  endfunction

  // Lowest k wins, so the search order starts at ptr+1 and wraps.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[IDW'((int'(ptr) + k) % NUM_REQ)]) begin
        grant_found = 1'b1;
        grant_id    = IDW'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  assign pipe_empty  = !s0_valid && !s1_valid;
  assign s1_load     = !s1_valid || resp_ready;
  assign s0_can_load = !s0_valid || s1_load;
  assign cfg_ok      = (cfg_msb != 5'd0) && (int'(cfg_msb) <= DATA_W);
  // A config request always takes priority over a new accept in the same cycle.
  assign accept_en   = live && (state != DRAIN) && !cfg_load && s0_can_load;
  assign accept      = grant_found && accept_en;
  assign req_ready   = accept ? (NUM_REQ'(1) << grant_id) : '0;

  assign resp_valid = s1_valid;
  assign resp_data  = s1_data;
  assign resp_id    = s1_id;
  assign busy       = s0_valid || s1_valid || (state == DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      m      <= MSB_RST;
      m_pend <= MSB_RST;
      live   <= 1'b0;
    end else begin
      live <= 1'b1;
      case (state)
        IDLE: begin
          if (cfg_load) begin
            if (cfg_ok) m <= cfg_msb;
          end else if (accept) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (cfg_load) begin
            if (pipe_empty) begin
              if (cfg_ok) m <= cfg_msb;
              state <= IDLE;
            end else begin
              m_pend <= cfg_ok ? cfg_msb : m;
              state  <= DRAIN;
            end
          end else if (pipe_empty && !accept) begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (pipe_empty) begin
            m     <= (cfg_load && cfg_ok) ? cfg_msb : m_pend;
            state <= IDLE;
          end else if (cfg_load && cfg_ok) begin
            m_pend <= cfg_msb;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Each item carries the m that was current at its accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= IDW'(NUM_REQ - 1);
      s0_valid <= 1'b0;
      s0_data  <= '0;
      s0_id    <= '0;
      s0_m     <= MSB_RST;
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_id    <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= s0_valid;
        if (s0_valid) begin
          s1_data <= round_fn(s0_data, s0_m);
          s1_id   <= s0_id;
        end
      end
      if (s0_can_load) begin
        s0_valid <= accept;
        if (accept) begin
          s0_data <= req_data[int'(grant_id)*DATA_W +: DATA_W];
          s0_id   <= grant_id;
          s0_m    <= m;
          ptr     <= grant_id;
        end
      end
    end
  end

endmodule

// File: tb/tb_err_round_sched.sv
// Directed bench for err_round_sched: rounding, wrap/saturate, round-robin order,
// back-pressure, reconfiguration drain and mid-stream reset.
`timescale 1ns/1ps
module tb_err_round_sched;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int IW = 2;
`ifdef ROUND_SAT_EN
  localparam logic [DW-1:0] EXP_FF80 = 16'hFF00;
`else
  localparam logic [DW-1:0] EXP_FF80 = 16'h0000;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic [4:0]        cfg_msb;
  logic              cfg_load;
  logic              resp_valid;
  logic [DW-1:0]     resp_data;
  logic [IW-1:0]     resp_id;
  logic              resp_ready;
  logic              busy;

  int vectors = 0;
  int errors  = 0;
  int acc;
  logic [IW+DW-1:0] exp_q[$];
  logic [IW+DW-1:0] e;
  logic [DW-1:0]    lane_exp [NR] = '{16'h1100, 16'h2100, 16'h3100, 16'h4100};

  err_round_sched #(.NUM_REQ(NR), .DATA_W(DW), .MSB_DEF(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .cfg_msb(cfg_msb), .cfg_load(cfg_load),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_id(resp_id),
    .resp_ready(resp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_m(input logic [4:0] v);
    cfg_msb  = v;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  // One item on one lane from IDLE; ends with the scheduler back in IDLE.
  task automatic send_one(input int lane, input logic [DW-1:0] d,
                          input logic [DW-1:0] exp, input string tag);
    req_valid = '0;
    req_valid[lane] = 1'b1;
    req_data[lane*DW +: DW] = d;
    #1;
    check({tag, "_rdy"}, 32'(req_ready), 32'(1 << lane));
    tick();
    req_valid = '0;
    check({tag, "_lat1"}, 32'(resp_valid), 0);
    tick();
    check({tag, "_valid"}, 32'(resp_valid), 1);
    check({tag, "_data"}, 32'(resp_data), 32'(exp));
    check({tag, "_id"}, 32'(resp_id), 32'(lane));
    tick();
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 4'b0001;
    req_data   = '0;
    cfg_msb    = 5'd0;
    cfg_load   = 1'b0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 32'(resp_valid), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_data", 32'(resp_data), 0);
    check("rst_id", 32'(resp_id), 0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;
    tick();

    // basic rounding at m=8
    send_one(0, 16'h1234, 16'h1200, "t1_a");
    send_one(0, 16'h1280, 16'h1300, "t1_b");
    send_one(0, 16'h12FF, 16'h1300, "t1_c");

    // carry-out and full-width pass-through, on lane 3 so the pointer ends at 3
    send_one(3, 16'hFF80, EXP_FF80, "t2_wrap");
    set_m(5'd16);
    send_one(3, 16'hABCD, 16'hABCD, "t2_m16");
    set_m(5'd8);

    // all lanes valid, full throughput, strict rotation from lane 0
    for (int k = 0; k < 8; k++) exp_q.push_back({IW'(k % NR), lane_exp[k % NR]});
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 16'h1080 + 16'(i * 16'h1000);
    for (int k = 0; k < 11; k++) begin
      if (k == 8) req_valid = '0;
      #1;
      if (k < 8) check("t3_rdy", 32'(req_ready), 32'(1 << (k % NR)));
      else       check("t3_rdy_off", 32'(req_ready), 0);
      if (k >= 2 && k < 10) begin
        e = exp_q.pop_front();
        check("t3_valid", 32'(resp_valid), 1);
        check("t3_id", 32'(resp_id), 32'(e[IW+DW-1:DW]));
        check("t3_data", 32'(resp_data), 32'(e[DW-1:0]));
      end else begin
        check("t3_idle", 32'(resp_valid), 0);
      end
      tick();
    end

    // back-pressure: two items fit, output held stable
    resp_ready = 1'b0;
    req_valid  = 4'b1111;
    req_data   = {16'h8888, 16'h7777, 16'h66C0, 16'h5555};
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      acc += int'(|(req_ready & req_valid));
      if (i >= 2) check("t4_hold", 32'(resp_data), 32'h5500);
      tick();
    end
    check("t4_accepts", 32'(acc), 2);
    check("t4_valid", 32'(resp_valid), 1);
    check("t4_id", 32'(resp_id), 0);
    resp_ready = 1'b1;
    req_valid  = '0;
    #1;
    check("t4_out0", 32'(resp_data), 32'h5500);
    tick();
    check("t4_out1", 32'(resp_data), 32'h6700);
    check("t4_id1", 32'(resp_id), 1);
    tick();
    check("t4_empty", 32'(resp_valid), 0);
    check("t4_busy", 32'(busy), 0);

    // reconfigure with two items in flight
    resp_ready = 1'b0;
    req_valid  = 4'b1100;
    req_data   = {16'h12FF, 16'h1234, 16'h0000, 16'h0000};
    #1;
    check("t5_rdy2", 32'(req_ready), 32'b0100);
    tick();
    check("t5_rdy3", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    cfg_msb   = 5'd4;
    cfg_load  = 1'b1;
    #1;
    check("t5_busy", 32'(busy), 1);
    tick();
    cfg_load  = 1'b0;
    req_valid = 4'b0001;
    req_data[0 +: DW] = 16'h1880;
    #1;
    check("t5_drain_rdy0", 32'(req_ready), 0);
    check("t5_drain_hold", 32'(resp_data), 32'h1200);
    tick();
    check("t5_drain_rdy1", 32'(req_ready), 0);
    resp_ready = 1'b1;
    #1;
    check("t5_old_a", 32'(resp_data), 32'h1200);
    check("t5_old_a_id", 32'(resp_id), 2);
    tick();
    check("t5_old_b", 32'(resp_data), 32'h1300);
    check("t5_old_b_id", 32'(resp_id), 3);
    check("t5_drain_rdy2", 32'(req_ready), 0);
    tick();
    check("t5_empty", 32'(resp_valid), 0);
    check("t5_drain_rdy3", 32'(req_ready), 0);
    check("t5_drain_busy", 32'(busy), 1);
    tick();
    check("t5_reopen", 32'(req_ready), 32'b0001);
    check("t5_idle_busy", 32'(busy), 0);
    tick();
    req_valid = '0;
    check("t5_new_lat1", 32'(resp_valid), 0);
    tick();
    check("t5_new_data", 32'(resp_data), 32'h2000);
    check("t5_new_id", 32'(resp_id), 0);
    tick();
    tick();

    // invalid m values are ignored; config blocks a same-cycle accept
    req_valid = 4'b0001;
    cfg_msb   = 5'd0;
    cfg_load  = 1'b1;
    #1;
    check("t5_cfg_block", 32'(req_ready), 0);
    tick();
    cfg_load = 1'b0;
    send_one(0, 16'h1880, 16'h2000, "t5_m0");
    set_m(5'd17);
    send_one(0, 16'h1880, 16'h2000, "t5_m17");

    // reset in the middle of a stream
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 16'h1080 + 16'(i * 16'h1000);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid0", 32'(resp_valid), 0);
    check("t6_ready0", 32'(req_ready), 0);
    check("t6_busy0", 32'(busy), 0);
    check("t6_data0", 32'(resp_data), 0);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_stale", 32'(resp_valid), 0);
    end
    send_one(0, 16'h1280, 16'h1300, "t6_m8");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
